// File: rtl/stopwatch_low_digits.sv
// stopwatch_low_digits
//   Lowest stage of the stopwatch seconds chain. A prescaler divides Clock
//   into a one-cycle count-enable tick (E). Two BCD digits (HEX0/HEX1)
//   advance on each tick. Each digit drives an active-low 7-segment display.
//   The "digit at 9" flags let the next digit counter decide when to carry.
// Ports:
//   Clock          system clock, all state on posedge
//   Reset          synchronous active-high, clears all state
//   hold           1 = run, 0 = pause (prescaler and digits freeze)
//   Clear          synchronous active-high zero of digits and prescaler
//   E              registered one-cycle tick, once per DIV running cycles
//   Q0, Q1         BCD digits 0..9 (HEX0, HEX1)
//   counter        Q0 == 9
//   counter2       Q1 == 9
//   Seg0, Seg1     active-low segments, bit0 = a .. bit6 = g

// seg7_dec: BCD digit to active-low 7-segment pattern; 10..15 blank.
module seg7_dec #(
  parameter int n = 4
) (
  input  logic [n-1:0] dig,
  output logic [6:0]   seg
);
  always_comb begin
    seg = 7'b1111111;
    case (dig)
      n'(0): seg = 7'b1000000;
      n'(1): seg = 7'b1111001;
      n'(2): seg = 7'b0100100;
      n'(3): seg = 7'b0110000;
      n'(4): seg = 7'b0011001;
      n'(5): seg = 7'b0010010;
      n'(6): seg = 7'b0000010;
      n'(7): seg = 7'b1111000;
      n'(8): seg = 7'b0000000;
      n'(9): seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module stopwatch_low_digits #(
  parameter int DIV   = 5000000,
  parameter int DIV_W = 23,
  parameter int n     = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         hold,
  input  logic         Clear,
  output logic         E,
  output logic [n-1:0] Q0,
  output logic [n-1:0] Q1,
  output logic         counter,
  output logic         counter2,
  output logic [6:0]   Seg0,
  output logic [6:0]   Seg1
);
  localparam int NUM_DIG = 2;

  logic [DIV_W-1:0] cnt;
  logic             at_top;

  assign at_top = (cnt == DIV_W'(DIV - 1));

  // Reset and Clear have identical effect, so they share one branch.
  // The prescaler and the digits only move while hold=1. A paused
  // prescaler keeps its phase, so a resume continues the interval
  // instead of restarting it.
  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      cnt <= '0;
      E   <= 1'b0;
      Q0  <= '0;
      Q1  <= '0;
    end else begin
      E <= hold && at_top;
      if (hold) begin
        cnt <= at_top ? '0 : cnt + DIV_W'(1);
        // E is already registered, so the digits step one edge after the
        // prescaler hits its terminal count. This keeps the flags aligned
        // with E for the downstream stage.
        if (E) begin
          if (Q0 == n'(9)) begin
            Q0 <= '0;
            Q1 <= (Q1 == n'(9)) ? '0 : Q1 + n'(1);
          end else begin
            Q0 <= Q0 + n'(1);
          end
        end
      end
    end
  end

  assign counter  = (Q0 == n'(9));
  assign counter2 = (Q1 == n'(9));

  logic [NUM_DIG-1:0][n-1:0] dig;
  logic [NUM_DIG-1:0][6:0]   seg;

  assign dig = {Q1, Q0};

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_seg
    seg7_dec #(.n(n)) u_dec (
      .dig (dig[g]),
      .seg (seg[g])
    );
  end

  assign Seg0 = seg[0];
  assign Seg1 = seg[1];
endmodule

// File: tb/tb_stopwatch_low_digits.sv
module tb_stopwatch_low_digits;
  localparam int DIV = 4;

  logic       Clock, Reset, hold, Clear;
  logic       E, counter, counter2;
  logic [3:0] Q0, Q1;
  logic [6:0] Seg0, Seg1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0] tbl [10];

  stopwatch_low_digits #(.DIV(DIV), .DIV_W(3), .n(4)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .hold     (hold),
    .Clear    (Clear),
    .E        (E),
    .Q0       (Q0),
    .Q1       (Q1),
    .counter  (counter),
    .counter2 (counter2),
    .Seg0     (Seg0),
    .Seg1     (Seg1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // one active edge, then settle to the falling edge for sampling/driving
  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // k full prescaler intervals starting at cnt=0; E must rise only on the
  // last edge of each interval
  task automatic run_ticks(input int k);
    for (int t = 0; t < k; t++)
      for (int i = 0; i < DIV; i++) begin
        step();
        chk("e_tick", E, (i == DIV - 1));
      end
  endtask

  task automatic chk_digits(input string tag, input int v);
    chk({tag, "_q0"}, Q0, v % 10);
    chk({tag, "_q1"}, Q1, v / 10);
  endtask

  initial begin
    tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100;
    tbl[3] = 7'b0110000; tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
    tbl[6] = 7'b0000010; tbl[7] = 7'b1111000; tbl[8] = 7'b0000000;
    tbl[9] = 7'b0010000;

    Reset = 1'b1; hold = 1'b0; Clear = 1'b0;
    step(); step();
    chk("rst_e", E, 0);
    chk_digits("rst", 0);
    chk("rst_c1", counter, 0);
    chk("rst_c2", counter2, 0);
    chk("rst_seg0", Seg0, 7'b1000000);
    chk("rst_seg1", Seg1, 7'b1000000);

    // first E in the cycle after the DIV-th running edge
    Reset = 1'b0; hold = 1'b1;
    run_ticks(1);
    chk_digits("t1", 0);
    run_ticks(1);
    chk_digits("t2", 1);
    chk("seg0_one", Seg0, 7'b1111001);
    run_ticks(1);
    chk_digits("t3", 2);
    run_ticks(1);
    chk_digits("t4", 3);

    // up to 9, then carry into Q1
    run_ticks(6);
    chk_digits("at9", 9);
    chk("at9_c1", counter, 1);
    chk("at9_c2", counter2, 0);
    run_ticks(1);
    chk_digits("at10", 10);
    chk("at10_c1", counter, 0);
    chk("at10_c2", counter2, 0);

    // walk to 99, checking every segment pattern along the way
    for (int v = 11; v <= 99; v++) begin
      run_ticks(1);
      chk_digits("walk", v);
      chk("walk_seg0", Seg0, tbl[v % 10]);
      chk("walk_seg1", Seg1, tbl[v / 10]);
    end
    chk("w99_e", E, 1);
    chk("w99_c1", counter, 1);
    chk("w99_c2", counter2, 1);
    step();
    chk_digits("wrap", 0);
    chk("wrap_e", E, 0);
    chk("wrap_c1", counter, 0);
    chk("wrap_c2", counter2, 0);

    // pause at cnt=2 for 7 cycles; E follows 2 edges after resume
    step();
    hold = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("hold_e", E, 0);
      chk("hold_q0", Q0, 0);
    end
    hold = 1'b1;
    step();
    chk("resume1_e", E, 0);
    step();
    chk("resume2_e", E, 1);

    // E=1 with hold=0: no increment, E drops
    hold = 1'b0;
    step();
    chk("ehold_e", E, 0);
    chk_digits("ehold", 0);
    hold = 1'b1;
    run_ticks(1);
    chk_digits("ehold_after", 0);

    // Clear on the E cycle at 57
    run_ticks(57);
    chk_digits("pre_clr", 57);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    chk("clr_e", E, 0);
    chk_digits("clr", 0);
    chk("clr_seg0", Seg0, 7'b1000000);
    chk("clr_seg1", Seg1, 7'b1000000);
    run_ticks(1);
    chk_digits("clr_t1", 0);
    run_ticks(1);
    chk_digits("clr_t2", 1);

    // Reset mid-count at 42 with cnt=3, held a few cycles
    run_ticks(40);
    step(); step(); step();
    chk_digits("pre_rst", 42);
    chk("pre_rst_e", E, 0);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_e", E, 0);
      chk_digits("mrst", 0);
      chk("mrst_seg0", Seg0, 7'b1000000);
      chk("mrst_seg1", Seg1, 7'b1000000);
    end
    Reset = 1'b0;
    run_ticks(1);
    chk_digits("post_rst", 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/stopwatch_low_digits.md
Name: stopwatch_low_digits

Overview:
Upstream stage of the stopwatch seconds chain. Divides Clock into a one-cycle count-enable tick and keeps the two lowest BCD digits (HEX0, HEX1) with active-low 7-segment drive. It produces the enable (E) and the two "digit at 9" flags (counter, counter2) that the next digit counter samples. That counter advances only when E=1 and both flags are 1, on the same edge.

Parameters:
DIV, 5000000, Clock cycles per tick (0.1 s at 50 MHz); must be >= 2
DIV_W, 23, prescaler width; 2^DIV_W >= DIV
n, 4, digit width

Ports:
Clock  input  1  system clock, all state on posedge
Reset  input  1  synchronous, active-high; clears all state
hold  input  1  1 = run, 0 = pause (same polarity as the downstream hold)
Clear  input  1  synchronous zero of digits and prescaler, active-high
E  output  1  one-cycle count-enable tick, registered
Q0  output  n  HEX0 BCD digit, 0..9
Q1  output  n  HEX1 BCD digit, 0..9
counter  output  1  combinational (Q0 == 9)
counter2  output  1  combinational (Q1 == 9)
Seg0  output  7  active-low segments for Q0, bit0 = seg a .. bit6 = seg g
Seg1  output  7  active-low segments for Q1

Behaviour:
- Priority per edge: Reset > Clear > hold == 0 > normal count.
- Reset or Clear: prescaler cnt=0, E=0, Q0=0, Q1=0. Hence counter=0, counter2=0, Seg0=Seg1=7'b1000000 ("0").
- Prescaler, when hold=1: cnt <= (cnt == DIV-1) ? 0 : cnt+1.
- Prescaler, when hold=0: cnt holds its value and resumes from it. There is no restart on resume.
- E register: E <= hold && (cnt == DIV-1).
- E timing: E is high exactly one cycle per DIV running cycles. The first E after Reset is visible in the cycle after the DIV-th running edge.
- Digit update happens on an edge where E=1 and hold=1:
  - Q0 <= (Q0 == 9) ? 0 : Q0+1.
  - If Q0 == 9, then Q1 <= (Q1 == 9) ? 0 : Q1+1; otherwise Q1 holds.
- E=1 with hold=0 on the same edge: digits do not change (matches the downstream hold-first rule). E is 0 on the next cycle.
- counter and counter2 are decoded from the current registered digits, so they are valid in the same cycle as E. The downstream stage sees E=1, counter=1, counter2=1 exactly on the edge where Q1:Q0 wraps 99 -> 00.
- Wrap-around: 99 -> 00 on one tick, with no extra output. Overflow is signalled only through counter and counter2.
- Clear during E=1: Clear wins; digits go to 0 and no increment happens.
- Reset or Clear held for several cycles: all state stays at 0 and E stays 0.
- Segment decode is combinational from Q0/Q1, standard DE-series active-low patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 (unreachable) = 1111111, blank.
- No combinational path from any input to E, Q0 or Q1. Seg0/Seg1 and the flags depend only on registers.

Test Plan:
- DIV=4, Reset 2 cycles then hold=1 -> E pulses every 4 cycles, exactly 1 cycle wide. Q0 reads 1,2,3 after the 1st, 2nd, 3rd E. Seg0 = 1111001 while Q0=1.
- Run 10 ticks -> Q0 goes 9 -> 0 and Q1 goes 0 -> 1 on the same edge. counter=1 only while Q0=9, counter2=0 throughout.
- Run to Q1:Q0=99 -> counter=counter2=1 in the cycle E=1. The next edge gives 00 and both flags drop. Hold E high with flags as a single-cycle downstream-advance window.
- hold=0 for 7 cycles starting when cnt=2 -> E stays 0, digits frozen. After hold=1, the next E arrives exactly 2 cycles later (cnt resumes at 2).
- Q1:Q0=57, assert Clear in the same cycle E=1 -> next cycle Q0=Q1=0, E=0, Seg0=Seg1=1000000. Counting restarts with a full DIV interval.
- Reset asserted mid-count (Q1:Q0=42, cnt=3) -> all outputs return to their reset values one edge later. No E until DIV running cycles after Reset is released.
